// File: rtl/eth_axis_pkg.sv
// eth_axis_pkg: shared encodings for the Ethernet AXI-stream TX path.
package eth_axis_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DISCARD} state_e;
  localparam int USER_BAD_BIT = 0;
endpackage

// File: rtl/eth_rr_arbiter.sv
// eth_rr_arbiter: rotating-priority encoder, first request searching upward from ptr+1 with wrap.
module eth_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int ID_WIDTH = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] grant,
  output logic                any
);
  logic [ID_WIDTH-1:0] idx;
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = ID_WIDTH'((int'(ptr) + i) % CHANNELS);
      grant = req[idx] ? idx : grant;
    end
  end
  assign any = |req;
endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-atomic round-robin merge of AXI-stream TX sources with
// per-channel tagging and max-frame-length truncation.
module eth_tx_frame_arbiter
  import eth_axis_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_FRAME_BEATS = 1200,
  parameter int ID_WIDTH        = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  input  logic [CHANNELS-1:0]            ch_enable,
  output logic [CHANNELS-1:0]            oversize_pulse,
  output logic                           busy
);
  localparam int CW = $clog2(MAX_FRAME_BEATS + 1);
  state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]    grant_q, grant_d, ptr_q, ptr_d, tid_q, tid_d, arb_grant;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d, in_data;
  logic [KEEP_WIDTH-1:0]  keep_q, keep_d, in_keep;
  logic [USER_WIDTH-1:0]  user_q, user_d, in_user;
  logic [CHANNELS-1:0]    pulse_q, pulse_d;
  logic                   valid_q, valid_d, last_q, last_d;
  logic                   arb_any, start, go, accept, pass_acc, in_last, trunc;
  eth_rr_arbiter #(.CHANNELS(CHANNELS), .ID_WIDTH(ID_WIDTH)) u_arb (
    .req  (s_axis_tvalid & ch_enable),
    .ptr  (ptr_q),
    .grant(arb_grant),
    .any  (arb_any)
  );
  assign in_data  = DATA_WIDTH'(s_axis_tdata >> (int'(grant_q) * DATA_WIDTH));
  assign in_keep  = KEEP_WIDTH'(s_axis_tkeep >> (int'(grant_q) * KEEP_WIDTH));
  assign in_user  = USER_WIDTH'(s_axis_tuser >> (int'(grant_q) * USER_WIDTH));
  assign in_last  = s_axis_tlast[grant_q];
  assign start    = (state_q == ST_IDLE) & arb_any;
  // DISCARD drains the tail without waiting on the output register
  assign go       = (state_q == ST_PASS) ? (m_axis_tready | ~valid_q) : (state_q == ST_DISCARD);
  assign accept   = go & s_axis_tvalid[grant_q];
  assign pass_acc = accept & (state_q == ST_PASS);
  assign trunc    = pass_acc & ~in_last & (cnt_q == CW'(MAX_FRAME_BEATS - 1));
  assign s_axis_tready = go ? (CHANNELS'(1) << grant_q) : '0;
  always_comb begin
    state_d = start ? ST_PASS : (accept & in_last) ? ST_IDLE : trunc ? ST_DISCARD : state_q;
    grant_d = start ? arb_grant : grant_q;
    ptr_d   = start ? arb_grant : ptr_q;
    cnt_d   = start ? '0 : pass_acc ? cnt_q + CW'(1) : cnt_q;
    valid_d = pass_acc | (valid_q & ~m_axis_tready);
    data_d  = pass_acc ? in_data : data_q;
    keep_d  = pass_acc ? in_keep : keep_q;
    last_d  = pass_acc ? (in_last | trunc) : last_q;
    user_d  = pass_acc ? (in_user | (USER_WIDTH'(trunc) << USER_BAD_BIT)) : user_q;
    tid_d   = pass_acc ? grant_q : tid_q;
    pulse_d = trunc ? (CHANNELS'(1) << grant_q) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= ID_WIDTH'(CHANNELS - 1);
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      tid_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      user_q  <= user_d;
      tid_q   <= tid_d;
      pulse_q <= pulse_d;
    end
  end
  assign m_axis_tdata   = data_q;
  assign m_axis_tkeep   = keep_q;
  assign m_axis_tvalid  = valid_q;
  assign m_axis_tlast   = last_q;
  assign m_axis_tuser   = user_q;
  assign m_axis_tid     = tid_q;
  assign oversize_pulse = pulse_q;
  assign busy           = state_q != ST_IDLE;
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb_eth_tx_frame_arbiter: directed frames against a frame-level round-robin model; dut_a uses
// the default frame limit, dut_b a limit of 4 beats, and sel routes the bench to one of them.
module tb_eth_tx_frame_arbiter;
  localparam int CH = 4, DW = 64, KW = 8;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    logic [1:0]    id;
  } beat_t;
  logic clk = 0, rst = 1, sel = 0, m_tready = 1, tr_mode = 0, tight = 0;
  logic [CH-1:0] en = '1, s_tvalid = '0, s_tlast = '0, s_tuser = '0, s_tready, va, vb;
  logic [CH*DW-1:0] s_tdata = '0;
  logic [CH*KW-1:0] s_tkeep = '0;
  logic [CH-1:0] rdy_a, rdy_b, pulse_a, pulse_b, o_pulse;
  logic [DW-1:0] data_a, data_b, o_data;
  logic [KW-1:0] keep_a, keep_b, o_keep;
  logic [0:0] user_a, user_b, o_user;
  logic [1:0] tid_a, tid_b, o_tid;
  logic valid_a, valid_b, last_a, last_b, busy_a, busy_b, o_valid, o_last, o_busy;
  int checks = 0, errors = 0, ncyc = 0, last_out = -1, out_beats = 0;
  int ptr_m[2] = '{3, 3};
  int pulse_cnt[CH] = '{0, 0, 0, 0};
  int exp_pulse[CH] = '{0, 0, 0, 0};
  beat_t src_q[CH][$];
  beat_t exp_q[$];
  int pend_len[CH][$];
  int pend_fid[CH][$];
  bit pend_bad[CH][$];
  bit prev_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  assign va = sel ? '0 : s_tvalid;
  assign vb = sel ? s_tvalid : '0;
  eth_tx_frame_arbiter dut_a (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(va),
    .s_axis_tready(rdy_a), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tdata(data_a),
    .m_axis_tkeep(keep_a), .m_axis_tvalid(valid_a), .m_axis_tready(m_tready), .m_axis_tlast(last_a),
    .m_axis_tuser(user_a), .m_axis_tid(tid_a), .ch_enable(en), .oversize_pulse(pulse_a), .busy(busy_a));
  eth_tx_frame_arbiter #(.MAX_FRAME_BEATS(4)) dut_b (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(vb),
    .s_axis_tready(rdy_b), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .m_axis_tdata(data_b),
    .m_axis_tkeep(keep_b), .m_axis_tvalid(valid_b), .m_axis_tready(m_tready), .m_axis_tlast(last_b),
    .m_axis_tuser(user_b), .m_axis_tid(tid_b), .ch_enable(en), .oversize_pulse(pulse_b), .busy(busy_b));
  assign s_tready = sel ? rdy_b : rdy_a;
  assign o_data   = sel ? data_b : data_a;
  assign o_keep   = sel ? keep_b : keep_a;
  assign o_valid  = sel ? valid_b : valid_a;
  assign o_last   = sel ? last_b : last_a;
  assign o_user   = sel ? user_b : user_a;
  assign o_tid    = sel ? tid_b : tid_a;
  assign o_pulse  = sel ? pulse_b : pulse_a;
  assign o_busy   = sel ? busy_b : busy_a;

  function automatic logic [DW-1:0] pat(int c, int f, int b);
    return {8'(c), 24'(f), 32'(b)};
  endfunction

  function automatic bit src_empty();
    for (int c = 0; c < CH; c++) if (src_q[c].size() != 0) return 0;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [75:0] got, input logic [75:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      beat_t b;
      b = src_q[c].size() != 0 ? src_q[c][0] : '0;
      s_tvalid[c] = src_q[c].size() != 0;
      s_tdata[c*DW +: DW] = b.data;
      s_tkeep[c*KW +: KW] = b.keep;
      s_tlast[c] = b.last;
      s_tuser[c] = b.user;
    end
  endtask

  task automatic send(input int c, input int len, input int fid, input bit bad);
    for (int b = 0; b < len; b++)
      src_q[c].push_back('{data: pat(c, fid, b), keep: b == len - 1 ? 8'h0F : 8'hFF,
                           last: b == len - 1, user: bad && b == len - 1, id: 2'(c)});
    pend_len[c].push_back(len);
    pend_fid[c].push_back(fid);
    pend_bad[c].push_back(bad);
    drive();
  endtask

  // Frame-level model: pick next pending enabled channel after the last winner, emit its frame
  // clipped to the limit; a clipped frame ends on the limit beat with the bad flag set.
  task automatic model_one(input logic [CH-1:0] mask, output bit got);
    int mx, c, len, fid, n;
    bit bad;
    mx = sel ? 4 : 1200;
    got = 0;
    c = 0;
    for (int k = 1; k <= CH && !got; k++) begin
      c = (ptr_m[int'(sel)] + k) % CH;
      got = mask[c] && pend_len[c].size() != 0;
    end
    if (got) begin
      ptr_m[int'(sel)] = c;
      len = pend_len[c].pop_front();
      fid = pend_fid[c].pop_front();
      bad = pend_bad[c].pop_front();
      n = len > mx ? mx : len;
      exp_pulse[c] += int'(len > mx);
      for (int b = 0; b < n; b++)
        exp_q.push_back('{data: pat(c, fid, b), keep: b == len - 1 ? 8'h0F : 8'hFF,
                          last: b == n - 1, user: b == n - 1 && (bad || len > mx), id: 2'(c)});
    end
  endtask

  task automatic plan_all(input logic [CH-1:0] mask);
    bit got;
    do model_one(mask, got); while (got);
  endtask

  task automatic cycle();
    logic [CH-1:0] hs;
    @(negedge clk);
    hs = s_tready & s_tvalid;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) if (hs[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
    m_tready = tr_mode ? ~m_tready : 1'b1;
    drive();
  endtask

  task automatic run(input int budget, input bit allow_pending);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !o_busy && (allow_pending || src_empty())) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d beats still expected after %0d cycles, required 0", exp_q.size(), n);
    end
    repeat (4) cycle();
  endtask

  task automatic chk_pulses();
    for (int c = 0; c < CH; c++) chk($sformatf("pulse_count_ch%0d", c), 76'(pulse_cnt[c]), 76'(exp_pulse[c]));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) pulse_cnt[c] += int'(o_pulse[c]);
      if (o_valid && m_tready) begin
        out_beats++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got tid=%0d data=%h, required no beat", o_tid, o_data);
        end else begin
          beat_t e, g;
          e = exp_q.pop_front();
          g = {o_data, o_keep, o_last, o_user, o_tid};
          if (g !== e) begin
            errors++;
            $display("FAIL beat: got data=%h keep=%h last=%b user=%b tid=%0d, required data=%h keep=%h last=%b user=%b tid=%0d",
                     g.data, g.keep, g.last, g.user, g.id, e.data, e.keep, e.last, e.user, e.id);
          end
          if (tight && last_out >= 0) begin
            checks++;
            if (ncyc - last_out != (prev_last ? 2 : 1)) begin
              errors++;
              $display("FAIL beat_spacing: got %0d cycles, required %0d", ncyc - last_out, prev_last ? 2 : 1);
            end
          end
          last_out = ncyc;
          prev_last = o_last;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int n, base;
    drive();
    repeat (3) cycle();
    chk("rst_valid", 76'(o_valid), 0);
    chk("rst_busy", 76'(o_busy), 0);
    chk("rst_tready", 76'(s_tready), 0);
    chk("rst_tid", 76'(o_tid), 0);
    chk("rst_last_user", 76'({o_last, o_user}), 0);
    chk("rst_pulse", 76'(o_pulse), 0);
    chk("rst_b_idle", 76'({valid_b, busy_b}), 0);
    rst = 0;
    // 1: four simultaneous 3-beat frames, ch3 flagged bad by its source
    tight = 1;
    for (int c = 0; c < CH; c++) send(c, 3, c, c == 3);
    plan_all('1);
    chk("t1_model_size", 76'(exp_q.size()), 12);
    chk("t1_model_order", 76'({exp_q[0].id, exp_q[3].id, exp_q[6].id, exp_q[9].id}), 76'(8'b00_01_10_11));
    chk("t1_model_bad", 76'({exp_q[11].last, exp_q[11].user}), 76'(2'b11));
    run(200, 0);
    tight = 0;
    last_out = -1;
    chk_pulses();
    // 2: 8-beat frame under alternating downstream ready
    tr_mode = 1;
    send(1, 8, 10, 0);
    plan_all('1);
    chk("t2_model_last", 76'({exp_q.size() == 8, exp_q[6].last, exp_q[7].last}), 76'(3'b101));
    run(300, 0);
    tr_mode = 0;
    m_tready = 1;
    // 5a: ch2 masked while everyone requests
    en = 4'b1011;
    for (int c = 0; c < CH; c++) send(c, 2, 20 + c, 0);
    plan_all(en);
    run(200, 1);
    chk("t5_ch2_never_granted", 76'(src_q[2].size()), 2);
    en = '1;
    plan_all(en);
    run(200, 0);
    // 5b: enable dropped mid-frame; current frame completes, next frame held off
    send(0, 6, 30, 0);
    send(0, 3, 31, 0);
    begin
      bit got;
      model_one('1, got);
    end
    n = 0;
    while (!o_busy && n < 20) begin
      cycle();
      n++;
    end
    chk("t5_busy", 76'(o_busy), 1);
    repeat (2) cycle();
    en = 4'b1110;
    run(200, 1);
    chk("t5_second_frame_held", 76'(src_q[0].size()), 3);
    en = '1;
    plan_all(en);
    run(200, 0);
    chk_pulses();
    // 3: limit-4 instance, 7-beat frame truncated, then a normal frame
    sel = 1;
    drive();
    send(2, 7, 40, 0);
    send(2, 3, 41, 0);
    plan_all('1);
    chk("t3_model_size", 76'(exp_q.size()), 7);
    chk("t3_model_trunc", 76'({exp_q[3].last, exp_q[3].user, exp_q[6].last, exp_q[6].user}), 76'(4'b1110));
    run(300, 0);
    chk("t3_pulse_ch2", 76'(pulse_cnt[2]), 1);
    // 4: frame ending exactly on the limit beat passes unmodified
    send(1, 4, 50, 0);
    plan_all('1);
    chk("t4_model_exact", 76'({exp_q.size() == 4, exp_q[3].last, exp_q[3].user}), 76'(3'b110));
    run(200, 0);
    chk_pulses();
    // 6: reset on beat 2 of a 5-beat frame
    sel = 0;
    drive();
    send(0, 5, 60, 0);
    plan_all('1);
    base = out_beats;
    n = 0;
    while (out_beats - base < 1 && n < 50) begin
      cycle();
      n++;
    end
    rst = 1;
    cycle();
    chk("t6_valid", 76'(o_valid), 0);
    chk("t6_busy", 76'(o_busy), 0);
    chk("t6_tready", 76'(s_tready), 0);
    exp_q.delete();
    for (int c = 0; c < CH; c++) begin
      src_q[c].delete();
      pend_len[c].delete();
      pend_fid[c].delete();
      pend_bad[c].delete();
    end
    ptr_m[0] = 3;
    rst = 0;
    send(1, 2, 61, 0);
    send(0, 2, 62, 0);
    plan_all('1);
    chk("t6_model_first", 76'({exp_q[0].id, exp_q[2].id}), 76'(4'b00_01));
    run(200, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
